router_out_fifo: RTL and testbench

- Per-port output buffer of the 1x3 router, directly downstream of router_sync; one instance per destination port (0/1/2).
- Accepts bytes on the router_sync wr_enb[n] strobe and returns full/empty to router_sync.
- Clears itself on router_sync's soft_rst_n when the destination does not read in time.
- Tracks packet boundaries so the read side knows how many bytes remain in the current packet.

---
 rtl/router_pkg.sv | 25 ++
 rtl/router_fifo_mem.sv | 24 ++
 rtl/router_out_fifo.sv | 106 ++++++++++
 tb/tb_router_out_fifo.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: default buffer geometry, header field layout, port codes.
package router_pkg;

  localparam int ROUTER_WIDTH  = 8;
  localparam int ROUTER_DEPTH  = 16;
  localparam int ROUTER_ADDR_W = 4;

  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 1;
  localparam int LEN_LSB  = 2;
  localparam int LEN_MSB  = 7;

  localparam logic [1:0] PORT0 = 2'b00;
  localparam logic [1:0] PORT1 = 2'b01;
  localparam logic [1:0] PORT2 = 2'b10;

  localparam int PKT_CNT_W = 7;
  typedef logic [PKT_CNT_W-1:0] pkt_cnt_t;

  // Bytes still to come after a header: payload length plus the trailing parity byte.
  function automatic pkt_cnt_t hdr_pkt_len(input logic [LEN_MSB:0] hdr);
    return {1'b0, hdr[LEN_MSB:LEN_LSB]} + pkt_cnt_t'(1);
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Plain storage array: synchronous write, asynchronous read, no reset.
// Zero-latency read; no flow control of its own, the owner gates i_wr_en.
module router_fifo_mem #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_dat,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_dat
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_dat;
  end

  assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/router_out_fifo.sv
// Per-port router output buffer with packet-length tracking; 1-cycle registered read, writes dropped when full.
// Optional sticky overflow/underflow flags when ROUTER_OUT_FIFO_ERR_EN is defined.
module router_out_fifo
  import router_pkg::*;
#(
  parameter int WIDTH  = ROUTER_WIDTH,
  parameter int DEPTH  = ROUTER_DEPTH,
  parameter int ADDR_W = ROUTER_ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_rst,
  input  logic             wr_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_enb,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             full,
  output logic             empty,
`ifdef ROUTER_OUT_FIFO_ERR_EN
  output logic             ovf_err,
  output logic             udf_err,
`endif
  output logic             pkt_busy
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  pkt_cnt_t        r_pkt_cnt;
  logic [WIDTH-1:0] r_dout;
  logic            r_dout_vld;

  logic            w_clr;
  logic            w_wr_acc;
  logic            w_rd_acc;
  logic [WIDTH:0]  w_rd_dat;

  assign w_clr    = rst | soft_rst;
  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign full     = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                    (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  // A flush cycle must not commit anything, including the memory write.
  assign w_wr_acc = wr_enb && !full && !w_clr;
  assign w_rd_acc = rd_enb && !empty;

  router_fifo_mem #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk      (clk),
    .i_wr_en  (w_wr_acc),
    .i_wr_addr(r_wr_ptr[ADDR_W-1:0]),
    .i_wr_dat ({lfd_state, din}),
    .i_rd_addr(r_rd_ptr[ADDR_W-1:0]),
    .o_rd_dat (w_rd_dat)
  );

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pkt_cnt  <= '0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      r_dout_vld <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_dout   <= w_rd_dat[WIDTH-1:0];
        // A header always reloads, even mid-packet: the newer packet wins.
        if (w_rd_dat[WIDTH])
          r_pkt_cnt <= hdr_pkt_len(w_rd_dat[LEN_MSB:0]);
        else if (r_pkt_cnt != '0)
          r_pkt_cnt <= r_pkt_cnt - pkt_cnt_t'(1);
      end
    end
  end

  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;
  assign pkt_busy = (r_pkt_cnt != '0);

`ifdef ROUTER_OUT_FIFO_ERR_EN
  logic r_ovf_err;
  logic r_udf_err;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_ovf_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else begin
      if (wr_enb && full)  r_ovf_err <= 1'b1;
      if (rd_enb && empty) r_udf_err <= 1'b1;
    end
  end

  assign ovf_err = r_ovf_err;
  assign udf_err = r_udf_err;
`endif

endmodule

// File: tb/tb_router_out_fifo.sv
// Randomized and directed checks of router_out_fifo against a queue-based packet FIFO model.
module tb_router_out_fifo;
  import router_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       soft_rst = 1'b0;
  logic       wr_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] din = 8'h00;
  logic       rd_enb = 1'b0;
  logic [7:0] dout;
  logic       dout_vld;
  logic       full;
  logic       empty;
  logic       pkt_busy;
`ifdef ROUTER_OUT_FIFO_ERR_EN
  logic       ovf_err;
  logic       udf_err;
`endif

  always #5 clk = ~clk;

  router_out_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .soft_rst (soft_rst),
    .wr_enb   (wr_enb),
    .lfd_state(lfd_state),
    .din      (din),
    .rd_enb   (rd_enb),
    .dout     (dout),
    .dout_vld (dout_vld),
    .full     (full),
    .empty    (empty),
`ifdef ROUTER_OUT_FIFO_ERR_EN
    .ovf_err  (ovf_err),
    .udf_err  (udf_err),
`endif
    .pkt_busy (pkt_busy)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: an ordered list of {header tag, byte} plus the packet bytes left to read.
  logic [8:0] m_q[$];
  int         m_left = 0;
  logic [7:0] m_dout = 8'h00;
  logic       m_vld  = 1'b0;
  logic       m_ovf  = 1'b0;
  logic       m_udf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r_rst, input bit s_rst, input bit w, input bit l,
                            input logic [7:0] d, input bit r);
    logic [8:0] e;
    bit was_full, was_empty;
    if (r_rst || s_rst) begin
      m_q.delete();
      m_left = 0; m_dout = 8'h00; m_vld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      was_full  = (m_q.size() == 16);
      was_empty = (m_q.size() == 0);
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_udf = 1'b1;
      m_vld = 1'b0;
      if (r && !was_empty) begin
        e = m_q.pop_front();
        m_dout = e[7:0];
        m_vld  = 1'b1;
        if (e[8])            m_left = int'(e[7:2]) + 1;
        else if (m_left > 0) m_left = m_left - 1;
      end
      if (w && !was_full) m_q.push_back({l, d});
    end
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ".dout"},     32'(dout),     32'(m_dout));
    chk({ph, ".dout_vld"}, 32'(dout_vld), 32'(m_vld));
    chk({ph, ".full"},     32'(full),     32'(m_q.size() == 16));
    chk({ph, ".empty"},    32'(empty),    32'(m_q.size() == 0));
    chk({ph, ".pkt_busy"}, 32'(pkt_busy), 32'(m_left != 0));
`ifdef ROUTER_OUT_FIFO_ERR_EN
    chk({ph, ".ovf_err"},  32'(ovf_err),  32'(m_ovf));
    chk({ph, ".udf_err"},  32'(udf_err),  32'(m_udf));
`endif
  endtask

  task automatic cyc(input string ph, input bit r_rst, input bit s_rst, input bit w,
                     input bit l, input logic [7:0] d, input bit r);
    rst = r_rst; soft_rst = s_rst; wr_enb = w; lfd_state = l; din = d; rd_enb = r;
    @(posedge clk);
    model_edge(r_rst, s_rst, w, l, d, r);
    #1;
    check_outputs(ph);
  endtask

  task automatic wr(input string ph, input bit l, input logic [7:0] d);
    cyc(ph, 0, 0, 1, l, d, 0);
  endtask

  task automatic rd(input string ph);
    cyc(ph, 0, 0, 0, 0, 8'h00, 1);
  endtask

  task automatic drain(input string ph);
    for (int i = 0; i < 17; i++) rd(ph);
  endtask

  initial begin
    logic [7:0] hdr;
    // Reset
    cyc("reset", 1, 0, 0, 0, 8'h00, 0);
    cyc("reset", 1, 0, 0, 0, 8'h00, 0);
    chk("reset.dout_zero", 32'(dout), 32'h00);
    chk("reset.empty_one", 32'(empty), 32'd1);

    // Fill, overflow attempt, drain in order
    for (int i = 0; i < 16; i++) wr("fill", 0, 8'(i));
    chk("fill.full_after_16", 32'(full), 32'd1);
    wr("fill_ovf", 0, 8'hFF);
    for (int i = 0; i < 16; i++) begin
      rd("fill_rd");
      chk("fill_rd.order", 32'(dout), 32'(i));
    end
    rd("fill_empty");
    chk("fill_empty.vld_low", 32'(dout_vld), 32'd0);

    // Packet header 0x0E: dest 2, length 3
    hdr = 8'h0E;
    chk("pkt.hdr_dest", 32'(hdr[ADDR_MSB:ADDR_LSB]), 32'(PORT2));
    wr("pkt", 1, hdr);
    wr("pkt", 0, 8'h11); wr("pkt", 0, 8'h22); wr("pkt", 0, 8'h33); wr("pkt", 0, 8'h44);
    rd("pkt_hdr");
    chk("pkt_hdr.busy", 32'(pkt_busy), 32'd1);
    rd("pkt_p"); rd("pkt_p"); rd("pkt_p");
    chk("pkt_p.busy_before_parity", 32'(pkt_busy), 32'd1);
    rd("pkt_parity");
    chk("pkt_parity.busy_low", 32'(pkt_busy), 32'd0);
    chk("pkt_parity.dout", 32'(dout), 32'h44);

    // Simultaneous access at occupancy 5, then at full
    for (int i = 0; i < 5; i++) wr("sim_pre", 0, 8'(8'h30 + i));
    for (int i = 0; i < 10; i++) cyc("sim5", 0, 0, 1, 0, 8'(8'h40 + i), 1);
    chk("sim5.occupancy", 32'(m_q.size()), 32'd5);
    drain("sim5_drain");
    for (int i = 0; i < 16; i++) wr("simf_pre", 0, 8'(8'h50 + i));
    cyc("simf", 0, 0, 1, 0, 8'hEE, 1);
    chk("simf.dout", 32'(dout), 32'h50);
    chk("simf.not_full", 32'(full), 32'd0);
    drain("simf_drain");

    // Soft reset with coincident write
    for (int i = 0; i < 7; i++) wr("srst_pre", (i == 0), (i == 0) ? 8'h20 : 8'(8'h60 + i));
    rd("srst_rd"); rd("srst_rd");
    cyc("srst", 0, 1, 1, 0, 8'hAA, 0);
    chk("srst.empty", 32'(empty), 32'd1);
    wr("srst_post", 0, 8'h5A);
    rd("srst_post");
    chk("srst_post.dout", 32'(dout), 32'h5A);

`ifdef ROUTER_OUT_FIFO_ERR_EN
    rd("err_udf");
    for (int i = 0; i < 17; i++) wr("err_ovf", 0, 8'(i));
    chk("err.both_set", 32'({ovf_err, udf_err}), 32'b11);
    drain("err_drain");
    chk("err.sticky", 32'({ovf_err, udf_err}), 32'b11);
    cyc("err_clr", 0, 1, 0, 0, 8'h00, 0);
`endif

    // Randomized traffic with write-heavy and read-heavy phases
    for (int i = 0; i < 1500; i++) begin
      int wp, rp;
      bit w, r, l, sr, hr;
      logic [7:0] d;
      wp = ((i / 60) % 2 == 0) ? 75 : 30;
      rp = 105 - wp;
      w  = ($urandom_range(99) < wp);
      r  = ($urandom_range(99) < rp);
      l  = ($urandom_range(7) == 0);
      d  = 8'($urandom);
      if (l) d[7:2] = 6'($urandom_range(5));
      sr = ($urandom_range(99) == 0);
      hr = ($urandom_range(299) == 0);
      cyc("rand", hr, sr, w, l, d, r);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
